// File: rtl/riscv_perf_region_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : riscv_perf_region_ctrl
// Brief   : Measures cycles and retired instructions across a sequence of
//           PC-bounded code regions and keeps per-region results for readout.
// Revision: 1.0 - initial release
// ============================================================================
module riscv_perf_region_ctrl #(
  parameter int NUM_REGIONS = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [31:0]      pc_i,
  input  logic             instruction_valid_i,
  input  logic             cfg_we_i,
  input  logic [2:0]       cfg_idx_i,
  input  logic [31:0]      cfg_start_pc_i,
  input  logic [31:0]      cfg_stop_pc_i,
  input  logic             arm_i,
  input  logic [2:0]       arm_nreg_i,
  input  logic             abort_i,
  input  logic             rd_en_i,
  input  logic [2:0]       rd_idx_i,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] rd_cycles_o,
  output logic [CNT_W-1:0] rd_instrs_o,
  output logic             rd_slot_valid_o,
  output logic             rd_sat_o,
  output logic [1:0]       state_o,
  output logic [2:0]       cur_region_o,
  output logic             region_done_o,
  output logic             done_o
);

  localparam int               c_IDX_W    = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [3:0]       c_NREG_MAX = 4'(NUM_REGIONS);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ARMED = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [2:0]             r_cur;
  logic [3:0]             r_nreg;
  logic [CNT_W-1:0]       r_cyc;
  logic [CNT_W-1:0]       r_ins;
  logic                   r_sat;

  logic [31:0]            r_start_pc [NUM_REGIONS];
  logic [31:0]            r_stop_pc  [NUM_REGIONS];
  logic [CNT_W-1:0]       r_slot_cyc [NUM_REGIONS];
  logic [CNT_W-1:0]       r_slot_ins [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] r_slot_valid;
  logic [NUM_REGIONS-1:0] r_slot_sat;

  logic                   r_rd_valid;
  logic [CNT_W-1:0]       r_rd_cyc;
  logic [CNT_W-1:0]       r_rd_ins;
  logic                   r_rd_slot_valid;
  logic                   r_rd_sat;
  logic                   r_region_done;
  logic                   r_done;

  logic [c_IDX_W-1:0]     w_cur_slot;
  logic [c_IDX_W-1:0]     w_cfg_slot;
  logic [c_IDX_W-1:0]     w_rd_slot;
  logic                   w_cfg_in_range;
  logic                   w_rd_in_range;
  logic [3:0]             w_nreg_arm;
  logic                   w_last;
  logic                   w_start_hit;
  logic                   w_stop_hit;
  logic [CNT_W-1:0]       w_cyc_inc;
  logic [CNT_W-1:0]       w_ins_inc;
  logic                   w_sat_inc;
  logic                   w_unused_idx_bits;

  logic                   w_cfg_ok;
  logic                   w_do_arm;
  logic                   w_do_start;
  logic                   w_do_count;
  logic                   w_do_stop;
  logic                   w_done_nxt;

  assign w_cur_slot        = r_cur[c_IDX_W-1:0];
  assign w_cfg_slot        = cfg_idx_i[c_IDX_W-1:0];
  assign w_rd_slot         = rd_idx_i[c_IDX_W-1:0];
  assign w_cfg_in_range    = (4'(w_cfg_slot) < c_NREG_MAX);
  assign w_rd_in_range     = (4'(rd_idx_i) < c_NREG_MAX);
  assign w_unused_idx_bits = ^cfg_idx_i;

  // A region count of zero or beyond the slot count means "all slots".
  assign w_nreg_arm = ((arm_nreg_i == 3'd0) || (4'(arm_nreg_i) > c_NREG_MAX))
                      ? c_NREG_MAX : 4'(arm_nreg_i);

  assign w_last      = (4'(r_cur) == (r_nreg - 4'd1));
  assign w_start_hit = instruction_valid_i && (pc_i == r_start_pc[w_cur_slot]);
  assign w_stop_hit  = instruction_valid_i && (pc_i == r_stop_pc[w_cur_slot]);

  // Saturating increments; the stored result includes the stop cycle itself.
  assign w_cyc_inc = (&r_cyc) ? r_cyc : (r_cyc + c_CNT_ONE);
  assign w_ins_inc = (instruction_valid_i && !(&r_ins)) ? (r_ins + c_CNT_ONE) : r_ins;
  assign w_sat_inc = r_sat | (&w_cyc_inc) | (&w_ins_inc);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: if (arm_i)       w_state_nxt = c_ARMED;
        c_ARMED:        if (w_start_hit) w_state_nxt = c_RUN;
        c_RUN:          if (w_stop_hit)  w_state_nxt = w_last ? c_DONE : c_ARMED;
        default:                         w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cfg_ok   = cfg_we_i && w_cfg_in_range && ((r_state == c_IDLE) || (r_state == c_DONE));
    w_do_arm   = !abort_i && arm_i && ((r_state == c_IDLE) || (r_state == c_DONE));
    w_do_start = !abort_i && (r_state == c_ARMED) && w_start_hit;
    w_do_count = !abort_i && (r_state == c_RUN);
    w_do_stop  = w_do_count && w_stop_hit;
    w_done_nxt = (w_state_nxt == c_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_cur         <= 3'd0;
      r_nreg        <= 4'd0;
      r_cyc         <= '0;
      r_ins         <= '0;
      r_sat         <= 1'b0;
      r_region_done <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_region_done <= w_do_stop;
      r_done        <= w_done_nxt;
      if (w_do_arm) begin
        r_cur  <= 3'd0;
        r_nreg <= w_nreg_arm;
      end
      if (w_do_start) begin
        r_cyc <= c_CNT_ONE;
        r_ins <= c_CNT_ONE;
        r_sat <= 1'b0;
      end else if (w_do_count) begin
        r_cyc <= w_cyc_inc;
        r_ins <= w_ins_inc;
        r_sat <= w_sat_inc;
      end
      if (w_do_stop && !w_last) begin
        r_cur <= r_cur + 3'd1;
      end
    end
  end

  // Region configuration and the result bank.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_start_pc[i] <= '0;
        r_stop_pc[i]  <= '0;
        r_slot_cyc[i] <= '0;
        r_slot_ins[i] <= '0;
      end
      r_slot_valid <= '0;
      r_slot_sat   <= '0;
    end else begin
      if (w_cfg_ok) begin
        r_start_pc[w_cfg_slot] <= cfg_start_pc_i;
        r_stop_pc[w_cfg_slot]  <= cfg_stop_pc_i;
      end
      if (w_do_arm) begin
        r_slot_valid <= '0;
        r_slot_sat   <= '0;
      end
      if (w_do_stop) begin
        r_slot_cyc[w_cur_slot]   <= w_cyc_inc;
        r_slot_ins[w_cur_slot]   <= w_ins_inc;
        r_slot_valid[w_cur_slot] <= 1'b1;
        r_slot_sat[w_cur_slot]   <= w_sat_inc;
      end
    end
  end

  // Read port sees pre-write contents when a slot is stored in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_rd_valid      <= 1'b0;
      r_rd_cyc        <= '0;
      r_rd_ins        <= '0;
      r_rd_slot_valid <= 1'b0;
      r_rd_sat        <= 1'b0;
    end else begin
      r_rd_valid <= rd_en_i;
      if (rd_en_i) begin
        if (w_rd_in_range) begin
          r_rd_cyc        <= r_slot_cyc[w_rd_slot];
          r_rd_ins        <= r_slot_ins[w_rd_slot];
          r_rd_slot_valid <= r_slot_valid[w_rd_slot];
          r_rd_sat        <= r_slot_sat[w_rd_slot];
        end else begin
          r_rd_cyc        <= '0;
          r_rd_ins        <= '0;
          r_rd_slot_valid <= 1'b0;
          r_rd_sat        <= 1'b0;
        end
      end
    end
  end

  assign rd_valid_o      = r_rd_valid;
  assign rd_cycles_o     = r_rd_cyc;
  assign rd_instrs_o     = r_rd_ins;
  assign rd_slot_valid_o = r_rd_slot_valid;
  assign rd_sat_o        = r_rd_sat;
  assign state_o         = r_state;
  assign cur_region_o    = r_cur;
  assign region_done_o   = r_region_done;
  assign done_o          = r_done;

endmodule
`default_nettype wire
